prog_loader: RTL
================

# prog_loader

Hardware boot loader: consumes a framed byte stream (valid/ready) and writes 32-bit words into the RISCVCore instruction and data memories through their write ports, holding the core in reset until a GO command arrives. It sits between a host-facing byte source (UART RX or debug bridge) and the `instr_mem` / `data_mem` write ports. It is the synthesizable replacement for backdoor memory preloading.

## Interface
Parameters:
- `IMEM_AW`, 10: instruction memory word-address width (depth 2^IMEM_AW words).
- `DMEM_AW`, 10: data memory word-address width.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  byte available.
- `in_ready`  out  1  loader accepts byte; transfer when `in_valid && in_ready`.
- `in_data`  in  8  stream byte.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  IMEM_AW  instruction-memory word index.
- `imem_wdata`  out  32  instruction word.
- `dmem_we`  out  1  one-cycle data-memory write strobe.
- `dmem_addr`  out  DMEM_AW  data-memory word index.
- `dmem_wdata`  out  32  data word.
- `core_rst`  out  1  reset to RISCVCore; 1 = core held.
- `busy`  out  1  frame in progress (state ≠ SYNC).
- `err`  out  1  sticky error: unknown command seen.

## Operation
- Frame: SYNC_BYTE, CMD, then for write commands ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT×4 data bytes. Words are little-endian (first byte = bits 7:0).
- CMD 8'h01 = write IMEM, 8'h02 = write DMEM, 8'h03 = GO (no payload).
- FSM states: SYNC → CMD → ADDR0 → ADDR1 → CNT0 → CNT1 → DATA → SYNC.
  - SYNC: a non-SYNC_BYTE byte is discarded and the FSM stays in SYNC.
  - CMD: 01/02 → ADDR0 and `core_rst`←1. 03 → SYNC and `core_rst`←0. Any other value → SYNC and `err`←1.
  - CNT1: if count = 0, go to SYNC with no writes; otherwise go to DATA.
  - DATA: a 2-bit byte counter assembles the word. On the 4th byte, issue the write, increment the address, and decrement the remaining count. Return to SYNC when the remaining count reaches 0.
- Address: ADDR is a 16-bit word index truncated to IMEM_AW/DMEM_AW. Increments wrap modulo 2^AW.
- Only the selected memory's `we` pulses; the other stays 0.
- Reset values: state SYNC, `in_ready` 0, `imem_we`/`dmem_we` 0, addr/wdata 0, `core_rst` 1, `busy` 0, `err` 0.
- `err` clears only on `rst`.

## Timing
- `in_ready` is registered: 0 during any cycle with `rst`=1, and 1 from the first cycle after reset deasserts onward. No backpressure otherwise.
- Back-to-back bytes every cycle are supported, so a data word can complete every 4 cycles. Gaps in `in_valid` only stretch the frame.
- Write latency: `*_we`, `*_addr` and `*_wdata` are valid together for exactly one cycle, on the cycle after the 4th data byte is accepted.
- `core_rst` changes on the cycle after the CMD byte is accepted.
- A write command issued after GO re-holds the core before any write lands.
- `rst` asserted mid-frame: the partial word is discarded, no write is issued, and all outputs return to their reset values on the next edge.
- `busy` is asserted from the cycle after the SYNC_BYTE is accepted until the cycle after the frame's last byte.

## Structure
- Package `prog_loader_pkg`: state enum, `CMD_WR_IMEM`/`CMD_WR_DMEM`/`CMD_GO` constants, default SYNC_BYTE.
- One sub-module, `loader_word_asm`: a byte-to-word shift register with 2-bit counter, inputs `clk`/`rst`/`byte_en`/`clr`, outputs a `word_done` pulse and a 32-bit word. The top-level FSM drives `clr` on entry to DATA.

## Test plan
- Bytes A5 01 00 00 01 00 93 00 50 00 (addi x1,x0,5 at IMEM 0) → single `imem_we` pulse, `imem_addr`=0, `imem_wdata`=32'h00500093, `dmem_we` never high, `core_rst` stays 1.
- DMEM write, addr 0x03FF, count 2, words 12345678 and 9ABCDEF0 → `dmem_we` at addr 0x3FF with 32'h12345678, then at addr 0x000 with 32'h9ABCDEF0 (wrap). Then bytes A5 03 → `core_rst` 0 one cycle after the 03 byte.
- Byte 3C, then A5 7F, then a valid IMEM frame → 3C ignored, `err`=1 after 7F, the valid frame still writes correctly, `err` remains 1.
- Write frame with count 0 → no write strobes and `busy` returns to 0. A subsequent A5 01 after GO → `core_rst` returns to 1.
- `rst` pulsed after 3 of 4 data bytes → no `imem_we`, `busy` 0, `core_rst` 1. A fresh frame then loads correctly.
- Same IMEM frame with random `in_valid` gaps of 0-5 cycles → identical write sequence to the gap-free run.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot loader.
//   state_t        - frame parser states
//   CMD_*          - command byte encodings
//   DEF_SYNC_BYTE  - default frame start marker
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_CMD,
        ST_ADDR0,
        ST_ADDR1,
        ST_CNT0,
        ST_CNT1,
        ST_DATA
    } state_t;

    localparam logic [7:0] CMD_WR_IMEM   = 8'h01;
    localparam logic [7:0] CMD_WR_DMEM   = 8'h02;
    localparam logic [7:0] CMD_GO        = 8'h03;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: little-endian byte-to-word assembler.
//   clk, rst   - clock, synchronous active-high reset
//   byte_en    - byte_in is a payload byte this cycle
//   clr        - restart assembly at byte 0
//   byte_in    - payload byte
//   word_done  - combinational: the 4th byte is present this cycle
//   word       - assembled word, valid while word_done is high
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] sr;    // bytes 0..2, byte 0 ends up in [7:0]

    // The 4th byte is not stored: it is combined directly so the top can
    // register the finished word on the same edge that accepts the byte.
    assign word_done = byte_en && (cnt == 2'd3);
    assign word      = {byte_in, sr};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
            sr  <= 24'd0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            sr  <= {byte_in, sr[23:8]};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte stream -> instruction/data memory writes, with
// control of the core reset.
//   clk, rst                        - clock, synchronous active-high reset
//   in_valid/in_ready/in_data       - byte stream input
//   imem_we/imem_addr/imem_wdata    - instruction memory write port
//   dmem_we/dmem_addr/dmem_wdata    - data memory write port
//   core_rst                        - 1 holds the core in reset
//   busy                            - frame in progress
//   err                             - sticky unknown-command flag
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         IMEM_AW   = 10,
    parameter int         DMEM_AW   = 10,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic               err
);

    // Address register only keeps the bits either memory can use; the
    // 16-bit frame address is truncated on load.
    localparam int AW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;

    state_t        state_q, state_d;
    logic          accept;
    logic          sel_dmem;
    logic [7:0]    addr_lo;
    logic [AW-1:0] addr_q;
    logic [15:0]   cnt_q;
    logic          asm_en, asm_clr, word_done;
    logic [31:0]   word;

    assign accept = in_valid && in_ready;
    assign busy   = (state_q != ST_SYNC);

    loader_word_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .byte_en   (asm_en),
        .clr       (asm_clr),
        .byte_in   (in_data),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        asm_en  = 1'b0;
        asm_clr = 1'b0;
        case (state_q)
            ST_SYNC:  if (accept && in_data == SYNC_BYTE) state_d = ST_CMD;
            ST_CMD:   if (accept) begin
                          if (in_data == CMD_WR_IMEM || in_data == CMD_WR_DMEM)
                              state_d = ST_ADDR0;
                          else
                              state_d = ST_SYNC;
                      end
            ST_ADDR0: if (accept) state_d = ST_ADDR1;
            ST_ADDR1: if (accept) state_d = ST_CNT0;
            ST_CNT0:  if (accept) state_d = ST_CNT1;
            ST_CNT1:  if (accept) begin
                          if ({in_data, cnt_q[7:0]} == 16'd0) begin
                              state_d = ST_SYNC;
                          end else begin
                              state_d = ST_DATA;
                              asm_clr = 1'b1;
                          end
                      end
            ST_DATA:  begin
                          asm_en = accept;
                          if (word_done && cnt_q == 16'd1) state_d = ST_SYNC;
                      end
            default:  state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            sel_dmem   <= 1'b0;
            addr_lo    <= 8'd0;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            core_rst   <= 1'b1;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'd0;
        end else begin
            in_ready <= 1'b1;
            imem_we  <= 1'b0;
            dmem_we  <= 1'b0;
            if (accept) begin
                case (state_q)
                    ST_CMD: begin
                        if (in_data == CMD_WR_IMEM || in_data == CMD_WR_DMEM) begin
                            core_rst <= 1'b1;
                            sel_dmem <= (in_data == CMD_WR_DMEM);
                        end else if (in_data == CMD_GO) begin
                            core_rst <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    ST_ADDR0: addr_lo     <= in_data;
                    ST_ADDR1: addr_q      <= AW'({in_data, addr_lo});
                    ST_CNT0:  cnt_q[7:0]  <= in_data;
                    ST_CNT1:  cnt_q[15:8] <= in_data;
                    default: ;
                endcase
            end
            if (word_done) begin
                if (sel_dmem) begin
                    dmem_we    <= 1'b1;
                    dmem_addr  <= addr_q[DMEM_AW-1:0];
                    dmem_wdata <= word;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr_q[IMEM_AW-1:0];
                    imem_wdata <= word;
                end
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q - 16'd1;
            end
        end
    end

endmodule
